// File: rtl/mem2_load_capture_pkg.sv
// Shared types for the MEM1->MEM2 load capture stage.
// Load type encoding and capture FSM state enum.
package mem2_load_capture_pkg;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
    logic [1:0] lr;
  } load_type_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] LR_NONE  = 2'd0;
  localparam logic [1:0] LR_LEFT  = 2'd1;
  localparam logic [1:0] LR_RIGHT = 2'd2;

  localparam load_type_t LOADTYPE_LB =
    '{1'b1, SZ_B, LR_NONE};
  localparam load_type_t LOADTYPE_LBU =
    '{1'b0, SZ_B, LR_NONE};
  localparam load_type_t LOADTYPE_LH =
    '{1'b1, SZ_H, LR_NONE};
  localparam load_type_t LOADTYPE_LHU =
    '{1'b0, SZ_H, LR_NONE};
  localparam load_type_t LOADTYPE_LW =
    '{1'b0, SZ_W, LR_NONE};
  localparam load_type_t LOADTYPE_LWL =
    '{1'b0, SZ_W, LR_LEFT};
  localparam load_type_t LOADTYPE_LWR =
    '{1'b0, SZ_W, LR_RIGHT};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } mem2_cap_state_e;

endpackage

// File: rtl/mem2_load_capture_if.sv
// MEM1 load request fields plus the dcache read response.
// master = MEM1/dcache side, slave = MEM2 capture stage.
interface mem2_load_capture_if
  import mem2_load_capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
);

  logic                 MEM1_Valid;
  logic                 MEM1_IsLoad;
  load_type_t           MEM1_LoadType;
  logic [ADDR_W-1:0]    MEM1_Addr;
  logic [REG_IDX_W-1:0] MEM1_RtIdx;
  logic [DATA_W-1:0]    MEM1_RtValue;
  logic                 dcache_rdata_ok;
  logic [DATA_W-1:0]    dcache_rdata;

  modport master (
    output MEM1_Valid,
    output MEM1_IsLoad,
    output MEM1_LoadType,
    output MEM1_Addr,
    output MEM1_RtIdx,
    output MEM1_RtValue,
    output dcache_rdata_ok,
    output dcache_rdata
  );

  modport slave (
    input MEM1_Valid,
    input MEM1_IsLoad,
    input MEM1_LoadType,
    input MEM1_Addr,
    input MEM1_RtIdx,
    input MEM1_RtValue,
    input dcache_rdata_ok,
    input dcache_rdata
  );

endinterface

// File: rtl/mem2_load_capture_rt_fwd.sv
// Stored rt index/value for LWL/LWR merge.
// Picks up WB writes while the load sits in MEM2.
module mem2_load_capture_rt_fwd #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load_i,
  input  logic                 occ_i,
  input  logic [REG_IDX_W-1:0] idx_i,
  input  logic [DATA_W-1:0]    val_i,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_dst_i,
  input  logic [DATA_W-1:0]    wb_res_i,
  output logic [DATA_W-1:0]    val_o
);

  logic [REG_IDX_W-1:0] idx_q;
  logic [DATA_W-1:0]    val_q;
  logic                 hit;

  // r0 is hardwired, so a WB to index 0 never counts
  assign hit = occ_i && !load_i && wb_we_i &&
               (wb_dst_i == idx_q) &&
               (wb_dst_i != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q <= '0;
      val_q <= '0;
    end else if (load_i) begin
      idx_q <= idx_i;
      val_q <= val_i;
    end else if (hit) begin
      val_q <= wb_res_i;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/mem2_load_capture.sv
// MEM1->MEM2 load stage register: waits for the dcache
// response, holds it across stalls, and drains flushed loads.
module mem2_load_capture
  import mem2_load_capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem2_load_capture_if.slave   up_i,
  input  logic                 MEM2_Stall,
  input  logic                 MEM2_Flush,
  input  logic                 WB_RegWrite,
  input  logic [REG_IDX_W-1:0] WB_Dst,
  input  logic [DATA_W-1:0]    WB_Result,
  output logic                 MEM2_Valid,
  output load_type_t           MEM2_LoadType,
  output logic [ADDR_W-1:0]    MEM2_RdAddr,
  output logic [DATA_W-1:0]    MEM2_RegRt,
  output logic [DATA_W-1:0]    MEM2_CacheRdata,
  output logic                 MEM2_DataWait
);

  mem2_cap_state_e   state_q, state_d;
  logic              valid_q;
  load_type_t        lt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hold_q;

  logic ok;
  logic data_wait;
  logic adv;
  logic new_load;
  logic latch;

  assign ok       = up_i.dcache_rdata_ok;
  assign new_load = up_i.MEM1_Valid && up_i.MEM1_IsLoad;
  // flush wins: nothing enters the stage in a flush cycle
  assign adv      = !MEM2_Stall && !data_wait && !MEM2_Flush;

  always_comb begin
    data_wait       = 1'b0;
    MEM2_CacheRdata = up_i.dcache_rdata;
    unique case (state_q)
      S_IDLE:  data_wait = 1'b0;
      S_WAIT:  data_wait = !ok;
      S_HOLD:  MEM2_CacheRdata = hold_q;
      S_DRAIN: data_wait = 1'b1;
      default: data_wait = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    if (MEM2_Flush) begin
      unique case (state_q)
        S_WAIT:  state_d = ok ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = ok ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (adv && new_load)
            state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ok && MEM2_Stall) begin
            latch   = 1'b1;
            state_d = S_HOLD;
          end else if (ok) begin
            state_d = new_load ? S_WAIT : S_IDLE;
          end
        end
        S_HOLD: begin
          if (adv)
            state_d = new_load ? S_WAIT : S_IDLE;
        end
        S_DRAIN: begin
          if (ok)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      lt_q    <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (MEM2_Flush) begin
        valid_q <= 1'b0;
        hold_q  <= '0;
      end else begin
        if (adv) begin
          valid_q <= new_load;
          lt_q    <= up_i.MEM1_LoadType;
          addr_q  <= up_i.MEM1_Addr;
        end
        if (latch)
          hold_q <= up_i.dcache_rdata;
      end
    end
  end

  mem2_load_capture_rt_fwd #(
    .DATA_W    (DATA_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_rt_fwd (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (adv),
    .occ_i    (valid_q),
    .idx_i    (up_i.MEM1_RtIdx),
    .val_i    (up_i.MEM1_RtValue),
    .wb_we_i  (WB_RegWrite),
    .wb_dst_i (WB_Dst),
    .wb_res_i (WB_Result),
    .val_o    (MEM2_RegRt)
  );

  assign MEM2_Valid    = valid_q;
  assign MEM2_LoadType = lt_q;
  assign MEM2_RdAddr   = addr_q;
  assign MEM2_DataWait = data_wait;

  // only one response is ever outstanding
  a_no_stray_ok : assert property (
    @(posedge clk) disable iff (!resetn)
    !(ok && (state_q == S_IDLE || state_q == S_HOLD))
  ) else $error("dcache_rdata_ok with no load waiting");

endmodule

// File: tb/tb_mem2_load_capture.sv
// Bench for mem2_load_capture: vector table plus
// hand sequences for flush, drain and reset corners.
module tb_mem2_load_capture;
  import mem2_load_capture_pkg::*;

  logic        clk;
  logic        resetn;
  logic        MEM2_Stall;
  logic        MEM2_Flush;
  logic        WB_RegWrite;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_Result;
  logic        MEM2_Valid;
  load_type_t  MEM2_LoadType;
  logic [31:0] MEM2_RdAddr;
  logic [31:0] MEM2_RegRt;
  logic [31:0] MEM2_CacheRdata;
  logic        MEM2_DataWait;

  mem2_load_capture_if bus ();

  mem2_load_capture dut (
    .clk             (clk),
    .resetn          (resetn),
    .up_i            (bus),
    .MEM2_Stall      (MEM2_Stall),
    .MEM2_Flush      (MEM2_Flush),
    .WB_RegWrite     (WB_RegWrite),
    .WB_Dst          (WB_Dst),
    .WB_Result       (WB_Result),
    .MEM2_Valid      (MEM2_Valid),
    .MEM2_LoadType   (MEM2_LoadType),
    .MEM2_RdAddr     (MEM2_RdAddr),
    .MEM2_RegRt      (MEM2_RegRt),
    .MEM2_CacheRdata (MEM2_CacheRdata),
    .MEM2_DataWait   (MEM2_DataWait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    load_type_t  lt;
    logic [31:0] addr;
    logic [4:0]  rtidx;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          wait_cyc;
    int          stall_cyc;
    logic        wb_en;
    logic [4:0]  wb_dst;
    logic [31:0] wb_val;
    logic [31:0] rt_exp;
  } vec_t;

  typedef struct {
    load_type_t  lt;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.MEM1_Valid      = 1'b0;
    bus.MEM1_IsLoad     = 1'b0;
    bus.MEM1_LoadType   = '0;
    bus.MEM1_Addr       = '0;
    bus.MEM1_RtIdx      = '0;
    bus.MEM1_RtValue    = '0;
    bus.dcache_rdata_ok = 1'b0;
    bus.dcache_rdata    = '0;
    MEM2_Stall          = 1'b0;
    MEM2_Flush          = 1'b0;
    WB_RegWrite         = 1'b0;
    WB_Dst              = '0;
    WB_Result           = '0;
  endtask

  task automatic drive_load(input load_type_t lt,
                            input logic [31:0] addr,
                            input logic [4:0] idx,
                            input logic [31:0] rt);
    bus.MEM1_Valid    = 1'b1;
    bus.MEM1_IsLoad   = 1'b1;
    bus.MEM1_LoadType = lt;
    bus.MEM1_Addr     = addr;
    bus.MEM1_RtIdx    = idx;
    bus.MEM1_RtValue  = rt;
  endtask

  // compare the stage outputs against the oldest expected load
  task automatic consume();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expected entry");
    end else begin
      e = sbq.pop_front();
      chk("sb_valid", 32'(MEM2_Valid), 32'd1);
      chk("sb_ltype", 32'(MEM2_LoadType), 32'(e.lt));
      chk("sb_addr", MEM2_RdAddr, e.addr);
      chk("sb_rt", MEM2_RegRt, e.rt);
      chk("sb_rdata", MEM2_CacheRdata, e.rdata);
      chk("sb_wait", 32'(MEM2_DataWait), 32'd0);
    end
  endtask

  task automatic run_load(input vec_t v);
    exp_t e;
    drive_idle();
    drive_load(v.lt, v.addr, v.rtidx, v.rt);
    e = '{v.lt, v.addr, v.rt_exp, v.rdata};
    sbq.push_back(e);
    #1;
    chk("entry_nowait", 32'(MEM2_DataWait), 32'd0);
    tick();
    bus.MEM1_Valid = 1'b0;
    chk("entered", 32'(MEM2_Valid), 32'd1);
    for (int i = 0; i < v.wait_cyc; i++) begin
      if (i == 0 && v.wb_en) begin
        WB_RegWrite = 1'b1;
        WB_Dst      = v.wb_dst;
        WB_Result   = v.wb_val;
      end
      #1;
      chk("wait_hi", 32'(MEM2_DataWait), 32'd1);
      tick();
      WB_RegWrite = 1'b0;
      if (i == 0 && v.wb_en)
        chk("rt_upd", MEM2_RegRt, v.rt_exp);
    end
    bus.dcache_rdata_ok = 1'b1;
    bus.dcache_rdata    = v.rdata;
    MEM2_Stall          = (v.stall_cyc != 0);
    #1;
    chk("ok_nowait", 32'(MEM2_DataWait), 32'd0);
    chk("ok_pass", MEM2_CacheRdata, v.rdata);
    if (v.stall_cyc == 0)
      consume();
    tick();
    bus.dcache_rdata_ok = 1'b0;
    bus.dcache_rdata    = $urandom;
    if (v.stall_cyc != 0) begin
      for (int i = 1; i < v.stall_cyc; i++) begin
        #1;
        chk("hold_st", 32'(dut.state_q), 32'(S_HOLD));
        chk("hold_data", MEM2_CacheRdata, v.rdata);
        chk("hold_nowait", 32'(MEM2_DataWait), 32'd0);
        tick();
        bus.dcache_rdata = $urandom;
      end
      MEM2_Stall = 1'b0;
      #1;
      chk("rel_st", 32'(dut.state_q), 32'(S_HOLD));
      consume();
      tick();
    end
    chk("after_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("after_valid", 32'(MEM2_Valid), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{LOADTYPE_LW, 32'h100, 5'd3, 32'h0,
                32'h12345678, 1, 0, 1'b0, 5'd0, 32'h0,
                32'h0};
    vecs[1] = '{LOADTYPE_LWL, 32'h203, 5'd4, 32'h11223344,
                32'hAABBCCDD, 1, 3, 1'b0, 5'd0, 32'h0,
                32'h11223344};
    vecs[2] = '{LOADTYPE_LWR, 32'h302, 5'd9, 32'h55667788,
                32'h0F0E0D0C, 2, 0, 1'b1, 5'd9, 32'hCAFEF00D,
                32'hCAFEF00D};
    vecs[3] = '{LOADTYPE_LB, 32'h401, 5'd0, 32'hDEADBEEF,
                32'h000000A5, 2, 0, 1'b1, 5'd0, 32'h00000001,
                32'hDEADBEEF};
    vecs[4] = '{LOADTYPE_LHU, 32'h502, 5'd7, 32'h01020304,
                32'h0000BEEF, 3, 1, 1'b1, 5'd8, 32'hFFFFFFFF,
                32'h01020304};
    vecs[5] = '{LOADTYPE_LH, 32'h604, 5'd12, 32'h0BADF00D,
                32'h00008001, 0, 0, 1'b0, 5'd0, 32'h0,
                32'h0BADF00D};

    drive_idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("rst_valid", 32'(MEM2_Valid), 32'd0);
    chk("rst_ltype", 32'(MEM2_LoadType), 32'd0);
    chk("rst_addr", MEM2_RdAddr, 32'd0);
    chk("rst_rt", MEM2_RegRt, 32'd0);
    chk("rst_wait", 32'(MEM2_DataWait), 32'd0);
    chk("rst_st", 32'(dut.state_q), 32'(S_IDLE));

    for (int i = 0; i < 6; i++)
      run_load(vecs[i]);

    // back-to-back: B enters in A's ok cycle
    drive_idle();
    drive_load(LOADTYPE_LBU, 32'h700, 5'd1, 32'h1);
    sbq.push_back('{LOADTYPE_LBU, 32'h700, 32'h1, 32'h11});
    tick();
    drive_load(LOADTYPE_LW, 32'h704, 5'd2, 32'h2);
    sbq.push_back('{LOADTYPE_LW, 32'h704, 32'h2, 32'h22});
    bus.dcache_rdata_ok = 1'b1;
    bus.dcache_rdata    = 32'h11;
    #1;
    consume();
    tick();
    drive_idle();
    #1;
    chk("b2b_st", 32'(dut.state_q), 32'(S_WAIT));
    chk("b2b_wait", 32'(MEM2_DataWait), 32'd1);
    chk("b2b_addr", MEM2_RdAddr, 32'h704);
    bus.dcache_rdata_ok = 1'b1;
    bus.dcache_rdata    = 32'h22;
    #1;
    consume();
    tick();
    drive_idle();

    // flush in WAIT, response two cycles later
    drive_load(LOADTYPE_LW, 32'h800, 5'd5, 32'h5);
    tick();
    drive_idle();
    MEM2_Flush = 1'b1;
    tick();
    MEM2_Flush = 1'b0;
    drive_load(LOADTYPE_LW, 32'h900, 5'd6, 32'h6);
    #1;
    chk("drain_st", 32'(dut.state_q), 32'(S_DRAIN));
    chk("drain_wait", 32'(MEM2_DataWait), 32'd1);
    chk("drain_valid", 32'(MEM2_Valid), 32'd0);
    tick();
    bus.dcache_rdata_ok = 1'b1;
    bus.dcache_rdata    = 32'h77777777;
    #1;
    chk("drain_ok_wait", 32'(MEM2_DataWait), 32'd1);
    tick();
    drive_idle();
    #1;
    chk("drain_exit_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("drain_exit_valid", 32'(MEM2_Valid), 32'd0);
    run_load('{LOADTYPE_LW, 32'hA00, 5'd10, 32'hA,
               32'h0A0A0A0A, 1, 0, 1'b0, 5'd0, 32'h0,
               32'hA});

    // flush and ok in the same cycle
    drive_idle();
    drive_load(LOADTYPE_LW, 32'hB00, 5'd11, 32'hB);
    tick();
    drive_idle();
    MEM2_Flush          = 1'b1;
    bus.dcache_rdata_ok = 1'b1;
    bus.dcache_rdata    = 32'hBBBBBBBB;
    tick();
    drive_idle();
    #1;
    chk("fok_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("fok_valid", 32'(MEM2_Valid), 32'd0);
    chk("fok_wait", 32'(MEM2_DataWait), 32'd0);

    // reset while waiting
    drive_load(LOADTYPE_LWL, 32'hC03, 5'd13, 32'hC);
    tick();
    drive_idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("mrst_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("mrst_valid", 32'(MEM2_Valid), 32'd0);
    chk("mrst_ltype", 32'(MEM2_LoadType), 32'd0);
    chk("mrst_addr", MEM2_RdAddr, 32'd0);
    chk("mrst_rt", MEM2_RegRt, 32'd0);
    chk("mrst_rdata", MEM2_CacheRdata, 32'd0);
    chk("mrst_wait", 32'(MEM2_DataWait), 32'd0);
    tick();

    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
